// File: rtl/immediate_encoder.sv
// immediate_encoder: finds the canonical {rot, imm8} rotated-immediate encoding of a constant, one even rotation per cycle.
module immediate_encoder #(
    parameter int DATA_W = 32,
    parameter int IMM_W  = 8,
    parameter int ROT_W  = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [DATA_W-1:0]      value_in,
    output logic                   resp_valid,
    input  logic                   resp_ready,
    output logic [ROT_W+IMM_W-1:0] imm12_out,
    output logic                   encodable
);
    typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_t;
    state_t                 state_q, state_d;
    logic [DATA_W-1:0]      shreg_q, shreg_d;
    logic [ROT_W-1:0]       rot_cnt_q, rot_cnt_d;
    logic [ROT_W+IMM_W-1:0] imm12_q, imm12_d;
    logic                   enc_q, enc_d;
    logic                   match;
    assign match      = shreg_q[DATA_W-1:IMM_W] == '0;
    assign req_ready  = state_q == IDLE;
    assign resp_valid = state_q == DONE;
    assign imm12_out  = imm12_q;
    assign encodable  = enc_q;
    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        rot_cnt_d = rot_cnt_q;
        imm12_d   = imm12_q;
        enc_d     = enc_q;
        case (state_q)
            IDLE: if (req_valid) begin
                shreg_d   = value_in;
                rot_cnt_d = '0;
                state_d   = SEARCH;
            end
            SEARCH: if (match) begin
                imm12_d = {rot_cnt_q, shreg_q[IMM_W-1:0]};
                enc_d   = 1'b1;
                state_d = DONE;
            end else if (rot_cnt_q == '1) begin
                imm12_d = '0;
                enc_d   = 1'b0;
                state_d = DONE;
            end else begin
                // shreg always holds ROL(value, 2*rot_cnt), so its low byte is the candidate imm8
                shreg_d   = {shreg_q[DATA_W-3:0], shreg_q[DATA_W-1:DATA_W-2]};
                rot_cnt_d = rot_cnt_q + 1'b1;
            end
            DONE: if (resp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            shreg_q   <= '0;
            rot_cnt_q <= '0;
            imm12_q   <= '0;
            enc_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            rot_cnt_q <= rot_cnt_d;
            imm12_q   <= imm12_d;
            enc_q     <= enc_d;
        end
    end
endmodule

// File: tb/tb_immediate_encoder.sv
// tb_immediate_encoder: scoreboard bench; stimulus queues expected responses, a monitor checks each response as it appears.
module tb_immediate_encoder;
    logic        clk = 0;
    logic        rst_n = 0;
    logic        req_valid = 0;
    logic        req_ready;
    logic [31:0] value_in = 0;
    logic        resp_valid;
    logic        resp_ready = 1;
    logic [11:0] imm12_out;
    logic        encodable;

    immediate_encoder #(.DATA_W(32), .IMM_W(8), .ROT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .value_in(value_in), .resp_valid(resp_valid), .resp_ready(resp_ready),
        .imm12_out(imm12_out), .encodable(encodable)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] value;
        logic [11:0] imm;
        logic        enc;
        int          lat;
    } exp_t;

    exp_t exp_q[$];
    int   compared = 0;
    int   mismatched = 0;
    int   cyc = 0;
    int   acc = 0;
    logic prev_v = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic logic [31:0] rol(input logic [31:0] x, input int s);
        int k = s % 32;
        return (k == 0) ? x : ((x << k) | (x >> (32 - k)));
    endfunction

    function automatic logic [31:0] ror(input logic [31:0] x, input int s);
        int k = s % 32;
        return (k == 0) ? x : ((x >> k) | (x << (32 - k)));
    endfunction

    // Brute-force reference: first even rotation whose rotated-back value fits in 8 bits
    function automatic exp_t model(input logic [31:0] v);
        exp_t e;
        logic [31:0] t;
        e.value = v; e.imm = 12'h000; e.enc = 1'b0; e.lat = 16;
        for (int r = 0; r < 16; r++) begin
            t = rol(v, 2 * r);
            if (!e.enc && t[31:8] == 24'h0) begin
                e.enc = 1'b1;
                e.imm = {r[3:0], t[7:0]};
                e.lat = r + 1;
            end
        end
        return e;
    endfunction

    always @(posedge clk) begin
        if (rst_n && req_valid && req_ready) acc = cyc + 1;
        cyc <= cyc + 1;
    end

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) prev_v = 1'b0;
        else begin
            if (resp_valid && !prev_v) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_response", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("imm12_out", {20'h0, imm12_out}, {20'h0, e.imm});
                    chk("encodable", {31'h0, encodable}, {31'h0, e.enc});
                    chk("latency", cyc - acc, e.lat);
                    if (encodable === 1'b1)
                        chk("decode", ror({24'h0, imm12_out[7:0]}, 2 * int'(imm12_out[11:8])), e.value);
                end
            end
            prev_v = resp_valid;
        end
    end

    task automatic send(input logic [31:0] v, input logic [11:0] ei, input logic ee, input int el);
        int n = 0;
        exp_t e;
        @(negedge clk);
        while (!req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk("req_ready_timeout", 32'd0, 32'd1);
        e.value = v; e.imm = ei; e.enc = ee; e.lat = el;
        exp_q.push_back(e);
        req_valid = 1'b1;
        value_in  = v;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        value_in  = $urandom;
    endtask

    task automatic send_model(input logic [31:0] v);
        exp_t e = model(v);
        send(v, e.imm, e.enc, e.lat);
    endtask

    task automatic wait_resp();
        int n = 0;
        while (!resp_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) chk("resp_valid_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        logic [31:0] v;
        int n;
        #2;
        chk("rst_req_ready", {31'h0, req_ready}, 32'd1);
        chk("rst_resp_valid", {31'h0, resp_valid}, 32'd0);
        chk("rst_imm12", {20'h0, imm12_out}, 32'd0);
        chk("rst_encodable", {31'h0, encodable}, 32'd0);
        #20 rst_n = 1;

        send(32'h000000FF, 12'h0FF, 1'b1, 1);
        send(32'hFF000000, 12'h4FF, 1'b1, 5);
        send(32'hF000000F, 12'h2FF, 1'b1, 3);
        send(32'h00000102, 12'h000, 1'b0, 16);
        send(32'h000003FC, 12'hFFF, 1'b1, 16);
        send(32'h00000004, 12'h004, 1'b1, 1);
        send(32'h00000000, 12'h000, 1'b1, 1);

        // Backpressure: hold the result in DONE and try to slip in another request
        @(negedge clk);
        while (!req_ready) @(negedge clk);
        resp_ready = 1'b0;
        send(32'hFF000000, 12'h4FF, 1'b1, 5);
        @(negedge clk);
        wait_resp();
        for (int i = 0; i < 5; i++) begin
            chk("bp_resp_valid", {31'h0, resp_valid}, 32'd1);
            chk("bp_imm12", {20'h0, imm12_out}, 32'h4FF);
            chk("bp_encodable", {31'h0, encodable}, 32'd1);
            chk("bp_req_ready", {31'h0, req_ready}, 32'd0);
            req_valid = (i == 2);
            value_in  = 32'h12345678;
            @(negedge clk);
        end
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_valid", {31'h0, resp_valid}, 32'd0);
        chk("bp_release_ready", {31'h0, req_ready}, 32'd1);

        // Reset during the third search cycle discards the request
        send(32'h00000102, 12'h000, 1'b0, 16);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        void'(exp_q.pop_back());
        chk("midrst_req_ready", {31'h0, req_ready}, 32'd1);
        chk("midrst_resp_valid", {31'h0, resp_valid}, 32'd0);
        chk("midrst_imm12", {20'h0, imm12_out}, 32'd0);
        chk("midrst_encodable", {31'h0, encodable}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        send(32'h000000FF, 12'h0FF, 1'b1, 1);

        for (int i = 0; i < 3000; i++) begin
            if (i % 2 == 0) v = ror({24'h0, 8'($urandom)}, 2 * $urandom_range(0, 15));
            else v = $urandom;
            send_model(v);
        end

        n = 0;
        while ((exp_q.size() != 0 || resp_valid) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk("drain_timeout", exp_q.size(), 32'd0);
        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
